// File: rtl/vme_seq_pkg.sv
// Shared types and constants for the VME command sequencer.
// Table entries hold one complete VME command plus its read-back check.
package vme_seq_pkg;

    localparam logic [31:0] VME_CMD_IDLE = 32'h00F8_0000;
    localparam int          VME_RD_BIT   = 25;
    localparam int          SEQ_DATA_W   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_NEXT,
        S_DONE
    } seq_state_e;

    typedef struct packed {
        logic                  start;
        logic [31:0]           cmd;
        logic [SEQ_DATA_W-1:0] data;
        logic [SEQ_DATA_W-1:0] exp_val;
        logic [SEQ_DATA_W-1:0] mask;
    } seq_entry_t;

endpackage

// File: rtl/vme_cmd_sequencer_if.sv
// Command/response handshake between the sequencer (master) and the VME
// command decoder (slave).
interface vme_cmd_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [31:0]       vme_cmd_reg;
    logic [DATA_W-1:0] vme_dat_reg_in;
    logic              vme_cmd_rd;
    logic              vme_dat_wr;
    logic [DATA_W-1:0] vme_dat_reg_out;

    modport master (
        output start, vme_cmd_reg, vme_dat_reg_in,
        input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out
    );

    modport slave (
        input  start, vme_cmd_reg, vme_dat_reg_in,
        output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out
    );
endinterface

// File: rtl/vme_seq_res_fifo.sv
// First-word-fall-through result FIFO; pushes into a full FIFO are dropped
// and flagged in a sticky overflow bit, unless a pop frees a slot that cycle.
module vme_seq_res_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             ovf_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign ovf_o   = ovf_q;
    assign dout_o  = mem[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
            if (push_i && !do_push) ovf_q <= 1'b1;
        end
    end
endmodule

// File: rtl/vme_cmd_sequencer.sv
// On-chip VME command player: steps through a loaded command table, captures
// read-back data into a FWFT FIFO and counts masked compare failures/timeouts.
module vme_cmd_sequencer
    import vme_seq_pkg::*;
#(
    parameter  int DATA_W    = SEQ_DATA_W,
    parameter  int DEPTH     = 64,
    parameter  int RES_DEPTH = 16,
    parameter  int TIMEOUT   = 1023,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic              ld_start,
    input  logic [31:0]       ld_cmd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [DATA_W-1:0] ld_expect,
    input  logic [DATA_W-1:0] ld_mask,
    input  logic [AW:0]       n_cmds,
    input  logic              loop_en,
    input  logic              run,
    input  logic              abort,
    vme_cmd_sequencer_if.master vme,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [AW-1:0]     first_err_idx,
    output logic              err_seen,
    output logic [15:0]       loop_cnt,
    input  logic              res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              res_empty,
    output logic              res_ovf
);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_entry_t  tbl [DEPTH];
    seq_entry_t  entry;
    seq_state_e  state_q;
    logic [AW-1:0]     idx_q, first_err_q;
    logic [AW:0]       n_q;
    logic [TW-1:0]     tmo_q;
    logic              is_rd_q, start_q, busy_q, done_q, err_seen_q;
    logic [31:0]       cmd_q;
    logic [DATA_W-1:0] dat_q;
    logic [15:0]       err_cnt_q, loop_cnt_q;
    logic              rsp_ok, fifo_push, cmp_err, tmo_err, rec_err, res_full_unused;

    // Table is frozen while a sequence runs so the live entry stays stable.
    always_ff @(posedge clk) begin
        if (ld_we && !busy_q)
            tbl[ld_addr] <= '{start: ld_start, cmd: ld_cmd, data: ld_data,
                              exp_val: ld_expect, mask: ld_mask};
    end

    assign entry     = tbl[idx_q];
    assign rsp_ok    = (state_q == S_WAIT_RESP) && vme.vme_dat_wr && !abort;
    assign fifo_push = rsp_ok && is_rd_q;
    assign cmp_err   = fifo_push && (entry.mask != '0) &&
                       ((vme.vme_dat_reg_out & entry.mask) != (entry.exp_val & entry.mask));
    assign tmo_err   = (state_q == S_WAIT_RESP) && !vme.vme_dat_wr && (tmo_q == '0) && !abort;
    assign rec_err   = cmp_err || tmo_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            tmo_q       <= '0;
            is_rd_q     <= 1'b0;
            start_q     <= 1'b0;
            cmd_q       <= VME_CMD_IDLE;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            loop_cnt_q  <= '0;
        end else begin
            start_q <= 1'b0;
            cmd_q   <= VME_CMD_IDLE;
            dat_q   <= '0;
            if (rec_err) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                if (!err_seen_q) begin
                    first_err_q <= idx_q;
                    err_seen_q  <= 1'b1;
                end
            end
            if (state_q == S_IDLE || state_q == S_DONE) begin
                if (run && n_cmds == '0) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end else if (run) begin
                    n_q        <= n_cmds;
                    idx_q      <= '0;
                    err_cnt_q  <= '0;
                    err_seen_q <= 1'b0;
                    loop_cnt_q <= '0;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b0;
                    state_q    <= S_ISSUE;
                end
            end else if (abort) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
            end else begin
                case (state_q)
                    S_ISSUE: if (vme.vme_cmd_rd) begin
                        start_q <= entry.start;
                        cmd_q   <= entry.cmd;
                        dat_q   <= entry.data;
                        is_rd_q <= entry.cmd[VME_RD_BIT];
                        tmo_q   <= TW'(TIMEOUT - 1);
                        state_q <= S_WAIT_RESP;
                    end
                    S_WAIT_RESP: begin
                        if (vme.vme_dat_wr || tmo_q == '0) state_q <= S_NEXT;
                        else                               tmo_q   <= tmo_q - 1'b1;
                    end
                    S_NEXT: begin
                        if ({1'b0, idx_q} == n_q - 1'b1) begin
                            if (loop_en) begin
                                idx_q      <= '0;
                                loop_cnt_q <= loop_cnt_q + 16'd1;
                                state_q    <= S_ISSUE;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    vme_seq_res_fifo #(.WIDTH(DATA_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (vme.vme_dat_reg_out),
        .pop_i   (res_rd),
        .dout_o  (res_data),
        .full_o  (res_full_unused),
        .empty_o (res_empty),
        .ovf_o   (res_ovf)
    );

    assign vme.start          = start_q;
    assign vme.vme_cmd_reg    = cmd_q;
    assign vme.vme_dat_reg_in = dat_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err_cnt            = err_cnt_q;
    assign first_err_idx      = first_err_q;
    assign err_seen           = err_seen_q;
    assign loop_cnt           = loop_cnt_q;
endmodule
